attn_param_sched: RTL
=====================

Name: attn_param_sched

Overview:
- Packet-granular round-robin scheduler for one attention head's per-layer parameter load.
- Merges the 14 parameter AXI-stream sources into one shared 32-bit write stream toward the head's parameter memories. The sources are W_Q/K/V, bias_Q/K/V, m_Q/K/V, e_Q/K/V, m_C and e_C.
- Enforces exactly one packet per source per layer and advances the layer index once all sources are served.
- Sits between the DMA s2mm channels and the attention-head wrapper's parameter inputs.

Parameters:
- NUM_SRC, 14, number of parameter source streams.
- LAYERS, 12, layers per full load.
- MAX_BEATS, 4096, maximum beats per packet. It sizes the beat counter.
- SRC_W, $clog2(NUM_SRC), width of the source id.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load from layer 0. Ignored unless in IDLE.
- s_tdata  in  NUM_SRC*32  packed source data; source i occupies bits [32i+31:32i].
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tlast  in  NUM_SRC  per-source last.
- s_tready  out  NUM_SRC  per-source ready.
- m_tdata  out  32  merged data.
- m_tvalid  out  1  merged valid.
- m_tlast  out  1  merged last.
- m_tready  in  1  merged ready.
- m_tid  out  SRC_W  id of the granted source.
- m_addr  out  $clog2(MAX_BEATS)  beat index within the current packet.
- layer  out  $clog2(LAYERS)  current layer.
- layer_done  out  1  one-cycle pulse when all sources have been served for the layer.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky overlength flag. Cleared only by reset or start.

Behaviour:
- Reset values: all outputs 0, state IDLE, served mask 0, round-robin pointer 0.
- States: IDLE, ARB, XFER, LEND.
- IDLE: on start, go to ARB. Also clear layer, the served mask, the pointer and err.
- ARB (1 cycle): choose the lowest index at or after the pointer, with wrap-around, that satisfies tvalid=1 and served=0.
  - A source is eligible only when both conditions hold.
  - On a hit: latch grant into m_tid, set m_addr=0 and go to XFER.
  - With no eligible source, stay in ARB.
  - No data moves in ARB. Arbitration latency is therefore 1 cycle, and back-to-back packets have a 1-cycle bubble.
- XFER: the path is combinational.
  - m_tdata, m_tvalid and m_tlast follow the granted source.
  - s_tready[grant] follows m_tready. All other s_tready bits are 0.
  - On each handshake (m_tvalid & m_tready), m_addr increments.
  - On the tlast handshake: set served[grant], set the pointer to grant+1 (mod NUM_SRC), and go to LEND if served is now all ones, otherwise to ARB.
- Overlength: a handshake at m_addr==MAX_BEATS-1 without tlast does the following.
  - That beat is forwarded with m_tlast forced to 1.
  - err is set.
  - The packet is treated as complete. Any remaining source beats belong to the next layer's packet from that source.
- LEND (1 cycle): pulse layer_done and clear the served mask.
  - If layer==LAYERS-1: set layer to 0 and go to IDLE.
  - Otherwise: increment layer and go to ARB.
- A source asserting tvalid while already served is held off with s_tready=0 until LEND.
- start pulses during busy have no effect.
- Reset mid-packet returns to IDLE immediately and drives all s_tready to 0. Upstream must restart its streams.
- m_tvalid is 0 outside XFER.
- AXI rule: tvalid and tdata from the source are passed through without inspection. The scheduler never drops a beat while the ready it presents is low.

Decomposition:
- Shared package attn_sched_pkg holds the following.
  - Source-index localparams SRC_W_Q=0 … SRC_e_C=13, in the wrapper's port order.
  - The state enum {IDLE, ARB, XFER, LEND}.
  - NUM_PARAM_SRC=14.
- One sub-module, rr_pick. It is a purely combinational round-robin priority picker: inputs eligible mask and pointer, outputs grant index and hit.

Test Plan:
- Reset, then start with all 14 sources valid, each sending a 4-beat packet → grants in order 0..13. m_addr goes 0,1,2,3 per packet. layer_done fires once, then layer=1.
- Source 5 valid before source 2 at layer start, pointer 0 → grant order 5 then 2. The pointer then moves to 3.
- Source 3 offers a second packet in the same layer → s_tready[3] stays 0 until after layer_done.
- m_tready toggles 1,0,1,0 during a packet → m_addr advances only on handshakes. No beat is lost or duplicated; a scoreboard compares data.
- MAX_BEATS=8, source 0 sends 10 beats without tlast → beat 7 is output with m_tlast=1 and err=1. The next 2 beats are held until the next layer.
- LAYERS=2, full load → layer goes 0→1→0, two layer_done pulses, busy drops to 0 in IDLE. Asserting rst low mid-XFER gives s_tready=0 in the same cycle and busy=0.

Source files
------------

// File: rtl/attn_sched_pkg.sv
// attn_sched_pkg: shared source ids and scheduler state encoding for attn_param_sched
package attn_sched_pkg;
  localparam int NUM_PARAM_SRC = 14;
  localparam int SRC_W_Q    = 0;
  localparam int SRC_W_K    = 1;
  localparam int SRC_W_V    = 2;
  localparam int SRC_bias_Q = 3;
  localparam int SRC_bias_K = 4;
  localparam int SRC_bias_V = 5;
  localparam int SRC_m_Q    = 6;
  localparam int SRC_m_K    = 7;
  localparam int SRC_m_V    = 8;
  localparam int SRC_e_Q    = 9;
  localparam int SRC_e_K    = 10;
  localparam int SRC_e_V    = 11;
  localparam int SRC_m_C    = 12;
  localparam int SRC_e_C    = 13;
  typedef enum logic [1:0] {IDLE, ARB, XFER, LEND} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, lowest eligible index at or after the pointer
//   elig_i  : eligible mask
//   ptr_i   : round-robin start index
//   grant_o : chosen index (0 when no hit)
//   hit_o   : some source is eligible
module rr_pick #(
  parameter int N = 14,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] grant_o,
  output logic         hit_o
);
  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    int j;
    j = 0;
    grant_o = '0;
    hit_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      j = j >= N ? j - N : j;
      if (elig_i[W'(j)]) begin
        grant_o = W'(j);
        hit_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/attn_param_sched.sv
// attn_param_sched: packet round-robin merge of the per-head parameter streams, one packet per source per layer
//   clk, rst (async, active low), start : control
//   s_tdata/s_tvalid/s_tlast/s_tready   : NUM_SRC AXI-stream sources, source i at s_tdata[32i+:32]
//   m_tdata/m_tvalid/m_tlast/m_tready   : merged 32-bit stream
//   m_tid, m_addr                       : granted source and beat index within its packet
//   layer, layer_done, busy, err        : progress, per-layer pulse, activity, sticky overlength flag
module attn_param_sched
  import attn_sched_pkg::*;
#(
  parameter int NUM_SRC   = NUM_PARAM_SRC,
  parameter int LAYERS    = 12,
  parameter int MAX_BEATS = 4096,
  parameter int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_SRC*32-1:0]        s_tdata,
  input  logic [NUM_SRC-1:0]           s_tvalid,
  input  logic [NUM_SRC-1:0]           s_tlast,
  output logic [NUM_SRC-1:0]           s_tready,
  output logic [31:0]                  m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  input  logic                         m_tready,
  output logic [SRC_W-1:0]             m_tid,
  output logic [$clog2(MAX_BEATS)-1:0] m_addr,
  output logic [$clog2(LAYERS)-1:0]    layer,
  output logic                         layer_done,
  output logic                         busy,
  output logic                         err
);
  localparam int AW = $clog2(MAX_BEATS);
  localparam int LW = $clog2(LAYERS);
  state_t state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d, ptr_q, ptr_d, pick;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [NUM_SRC-1:0] served_q, served_d, served_set;
  logic err_q, err_d, hit, xfer, last_beat, hs;
  rr_pick #(.N(NUM_SRC), .W(SRC_W)) u_pick (
    .elig_i (s_tvalid & ~served_q),
    .ptr_i  (ptr_q),
    .grant_o(pick),
    .hit_o  (hit)
  );
  assign xfer       = state_q == XFER;
  assign last_beat  = addr_q == AW'(MAX_BEATS - 1);
  assign m_tvalid   = xfer & s_tvalid[grant_q];
  // The final beat slot always closes the packet, even without a source tlast.
  assign m_tlast    = xfer & (s_tlast[grant_q] | last_beat);
  assign m_tdata    = xfer ? s_tdata[{grant_q, 5'd0} +: 32] : '0;
  assign s_tready   = xfer ? NUM_SRC'(m_tready) << grant_q : '0;
  assign hs         = m_tvalid & m_tready;
  assign served_set = served_q | NUM_SRC'(1) << grant_q;
  assign m_tid      = grant_q;
  assign m_addr     = addr_q;
  assign layer      = layer_q;
  assign layer_done = state_q == LEND;
  assign busy       = state_q != IDLE;
  assign err        = err_q;
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    layer_d  = layer_q;
    served_d = served_q;
    ptr_d    = ptr_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = ARB;
        layer_d  = '0;
        served_d = '0;
        ptr_d    = '0;
        err_d    = 1'b0;
      end
      ARB: if (hit) begin
        grant_d = pick;
        addr_d  = '0;
        state_d = XFER;
      end
      XFER: if (hs) begin
        addr_d = addr_q + 1'b1;
        err_d  = err_q | (last_beat & ~s_tlast[grant_q]);
        if (m_tlast) begin
          served_d = served_set;
          ptr_d    = grant_q == SRC_W'(NUM_SRC - 1) ? '0 : grant_q + 1'b1;
          state_d  = &served_set ? LEND : ARB;
        end
      end
      LEND: begin
        served_d = '0;
        layer_d  = layer_q == LW'(LAYERS - 1) ? '0 : layer_q + 1'b1;
        state_d  = layer_q == LW'(LAYERS - 1) ? IDLE : ARB;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      addr_q   <= '0;
      layer_q  <= '0;
      served_q <= '0;
      ptr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      layer_q  <= layer_d;
      served_q <= served_d;
      ptr_q    <= ptr_d;
      err_q    <= err_d;
    end
  end
endmodule
